lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request in flight, single-cycle memory issue.
// Optional LSU_CTRL_STATS_EN adds saturating load/store counters.
module lsu_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_err,
  output logic              mem_enable,
  output logic              mem_read_writenot,
  output logic [ADDR_W-1:0] mem_read_address1,
  output logic [ADDR_W-1:0] mem_read_address2,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data1,
  input  logic [DATA_W-1:0] mem_out_data2
`ifdef LSU_CTRL_STATS_EN
  ,
  output logic [15:0]       ld_count,
  output logic [15:0]       st_count
`endif
);

  localparam logic [1:0] OP_LDP = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d;
  logic [ADDR_W-1:0]   addr2_q, addr2_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d;
  logic [DATA_W-1:0]   rd2_q, rd2_d;
  logic                err_q, err_d;
  logic                accept;

  assign accept = req_valid & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    wdata_d = wdata_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr1_d = req_addr1;
          addr2_d = req_addr2;
          wdata_d = req_wdata;
          rd1_d   = '0;
          rd2_d   = '0;
          err_d   = (req_op == OP_RSV);
          state_d = (req_op == OP_RSV) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        state_d = (op_q == OP_ST) ? RESP : CAPT;
      end
      CAPT: begin
        rd1_d   = mem_out_data1;
        rd2_d   = (op_q == OP_LDP) ? mem_out_data2 : '0;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      wdata_q <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      wdata_q <= wdata_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data1 = rd1_q;
  assign rsp_data2 = rd2_q;
  assign rsp_err   = err_q;

  // rst gates the enable so a reset landing in ISSUE never touches memory
  assign mem_enable        = (state_q == ISSUE) & ~rst;
  assign mem_read_writenot = (op_q != OP_ST);
  assign mem_read_address1 = addr1_q;
  assign mem_read_address2 = addr2_q;
  assign mem_write_address = addr1_q;
  assign mem_in_data       = wdata_q;

`ifdef LSU_CTRL_STATS_EN
  logic [15:0] ld_cnt_q;
  logic [15:0] st_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_q <= '0;
      st_cnt_q <= '0;
    end else if (accept) begin
      if (!req_op[1] && ld_cnt_q != 16'hFFFF) ld_cnt_q <= ld_cnt_q + 16'd1;
      if (req_op == OP_ST && st_cnt_q != 16'hFFFF) st_cnt_q <= st_cnt_q + 16'd1;
    end
  end

  assign ld_count = ld_cnt_q;
  assign st_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: transaction-level model, per-cycle compare,
// directed literal cases then randomized traffic with resets.
module tb_lsu_ctrl;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [AW-1:0] req_addr1 = '0, req_addr2 = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data1, rsp_data2;
  logic          rsp_err;
  logic          mem_enable, mem_rnw;
  logic [AW-1:0] mem_ra1, mem_ra2, mem_wa;
  logic [DW-1:0] mem_in_data;
  logic [DW-1:0] mem_out1 = '0, mem_out2 = '0;
`ifdef LSU_CTRL_STATS_EN
  logic [15:0]   ld_count, st_count;
`endif

  lsu_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr1(req_addr1), .req_addr2(req_addr2), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_err(rsp_err),
    .mem_enable(mem_enable), .mem_read_writenot(mem_rnw),
    .mem_read_address1(mem_ra1), .mem_read_address2(mem_ra2),
    .mem_write_address(mem_wa), .mem_in_data(mem_in_data),
    .mem_out_data1(mem_out1), .mem_out_data2(mem_out2)
`ifdef LSU_CTRL_STATS_EN
    , .ld_count(ld_count), .st_count(st_count)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // environment memory, driven only by the DUT (plus bench preload)
  logic          clr = 1'b0, pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [DW-1:0] pre_d = '0;
  logic [DW-1:0] mem [0:63];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (mem_enable) begin
      if (mem_rnw) begin
        mem_out1 <= mem[mem_ra1];
        mem_out2 <= mem[mem_ra2];
      end else begin
        mem[mem_wa] <= mem_in_data;
      end
    end
  end

  // literal capture of memory activity
  int            en_cnt = 0;
  logic [AW-1:0] l_wa = '0;
  logic [DW-1:0] l_wd = '0;
  logic          l_rnw = 1'b1;
  always @(posedge clk) begin
    if (mem_enable) begin
      en_cnt <= en_cnt + 1;
      l_wa   <= mem_wa;
      l_wd   <= mem_in_data;
      l_rnw  <= mem_rnw;
    end
  end

  // transaction-level reference model
  logic [DW-1:0] ref_mem [0:63];
  logic          busy = 1'b0;
  int            m_k = 0;
  int            m_lat = 0;
  logic [1:0]    m_op = '0;
  logic [AW-1:0] m_a1 = '0, m_a2 = '0;
  logic [DW-1:0] m_wd = '0, m_d1 = '0, m_d2 = '0;
  logic          m_err = 1'b0;
  logic [15:0]   m_ld = '0, m_st = '0;
  logic          preset_ld = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) ref_mem[i] <= '0;
    end else if (pre_we) begin
      ref_mem[pre_a] <= pre_d;
    end
    if (rst) begin
      busy <= 1'b0;
      m_ld <= '0;
      m_st <= '0;
    end else if (!busy) begin
      if (preset_ld) m_ld <= 16'hFFFF;
      if (req_valid) begin
        busy  <= 1'b1;
        m_k   <= 0;
        m_op  <= req_op;
        m_a1  <= req_addr1;
        m_a2  <= req_addr2;
        m_wd  <= req_wdata;
        m_err <= (req_op == 2'd3);
        m_d1  <= '0;
        m_d2  <= '0;
        m_lat <= (req_op == 2'd3) ? 1 : (req_op == 2'd2) ? 2 : 3;
        if (req_op < 2'd2 && m_ld != 16'hFFFF) m_ld <= m_ld + 16'd1;
        if (req_op == 2'd2 && m_st != 16'hFFFF) m_st <= m_st + 16'd1;
      end
    end else begin
      m_k <= m_k + 1;
      if (m_k == 0 && m_op != 2'd3) begin
        if (m_op == 2'd2) begin
          ref_mem[m_a1] <= m_wd;
        end else begin
          m_d1 <= ref_mem[m_a1];
          m_d2 <= (m_op == 2'd1) ? ref_mem[m_a2] : '0;
        end
      end
      if (m_k >= m_lat - 1 && rsp_ready) busy <= 1'b0;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("mem_enable_in_reset", mem_enable, 0);
    end else begin
      logic exp_en, exp_v;
      exp_en = busy && m_k == 0 && m_op != 2'd3;
      exp_v  = busy && m_k >= m_lat - 1;
      chk("req_ready", req_ready, !busy);
      chk("rsp_valid", rsp_valid, exp_v);
      chk("mem_enable", mem_enable, exp_en);
      if (exp_en) begin
        chk("mem_rnw", mem_rnw, m_op != 2'd2);
        if (m_op == 2'd2) begin
          chk("mem_wa", mem_wa, m_a1);
          chk("mem_wdata", mem_in_data, m_wd);
        end else begin
          chk("mem_ra1", mem_ra1, m_a1);
          if (m_op == 2'd1) chk("mem_ra2", mem_ra2, m_a2);
        end
      end
      if (exp_v) begin
        chk("rsp_data1", rsp_data1, m_d1);
        chk("rsp_data2", rsp_data2, m_d2);
        chk("rsp_err", rsp_err, m_err);
      end
`ifdef LSU_CTRL_STATS_EN
      if (!preset_ld) begin
        chk("ld_count", ld_count, m_ld);
        chk("st_count", st_count, m_st);
      end
`endif
    end
  end

  // response acceptance
  logic rr_force = 1'b1, rr_val = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [DW-1:0] wd);
    int n = 0;
    bit done = 0;
    req_valid = 1'b1;
    req_op = op; req_addr1 = a1; req_addr2 = a2; req_wdata = wd;
    while (!done) begin
      @(negedge clk);
      if (req_ready) done = 1;
      else if (++n > 60) begin
        chk("req_accept_timeout", 1, 0);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 2'($urandom); req_addr1 = AW'($urandom);
    req_addr2 = AW'($urandom); req_wdata = DW'($urandom);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
      if (lat > 20) begin
        chk("rsp_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic release_rsp();
    rr_val = 1'b1;
    wait_idle();
    rr_val = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  initial begin
    int lat, en0, nmis;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_data1", rsp_data1, 0);
    chk("reset_mem_enable", mem_enable, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; clr = 1'b0;

    // store 0xA5 -> 0x05
    en0 = en_cnt;
    do_req(2'd2, 6'h05, 6'h00, 8'hA5);
    wait_rsp(lat);
    chk("st_latency", lat, 2);
    chk("st_rsp_data1", rsp_data1, 0);
    chk("st_rsp_err", rsp_err, 0);
    chk("st_en_pulses", en_cnt - en0, 1);
    chk("st_waddr", l_wa, 6'h05);
    chk("st_wdata", l_wd, 8'hA5);
    chk("st_rnw", l_rnw, 0);
    release_rsp();
    chk("st_mem", mem[5'h05], 8'hA5);

    // load pair
    preload(6'h3F, 8'h3C);
    do_req(2'd1, 6'h05, 6'h3F, 8'h00);
    wait_rsp(lat);
    chk("ldp_latency", lat, 3);
    chk("ldp_data1", rsp_data1, 8'hA5);
    chk("ldp_data2", rsp_data2, 8'h3C);
    release_rsp();

    // load single with response held off
    do_req(2'd0, 6'h3F, 6'h05, 8'h00);
    wait_rsp(lat);
    chk("ld_latency", lat, 3);
    repeat (4) begin
      @(negedge clk);
      chk("ld_hold_valid", rsp_valid, 1);
      chk("ld_hold_data1", rsp_data1, 8'h3C);
      chk("ld_hold_data2", rsp_data2, 0);
      chk("ld_hold_req_ready", req_ready, 0);
    end
    release_rsp();

    // reserved op
    en0 = en_cnt;
    do_req(2'd3, 6'h01, 6'h02, 8'h03);
    wait_rsp(lat);
    chk("rsv_latency", lat, 1);
    chk("rsv_err", rsp_err, 1);
    chk("rsv_data1", rsp_data1, 0);
    release_rsp();
    chk("rsv_no_mem", en_cnt - en0, 0);

    // reset during ISSUE of a store
    preload(6'h10, 8'h11);
    do_req(2'd2, 6'h10, 6'h00, 8'h77);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_issue_en", mem_enable, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 0);
    end
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_kept", mem[6'h10], 8'h11);
    @(posedge clk);
    #1;

`ifdef LSU_CTRL_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rr_val = 1'b1;
    do_req(2'd0, 6'h01, 6'h00, 8'h00);
    do_req(2'd2, 6'h02, 6'h00, 8'h12);
    do_req(2'd1, 6'h03, 6'h04, 8'h00);
    do_req(2'd3, 6'h05, 6'h00, 8'h00);
    do_req(2'd2, 6'h06, 6'h00, 8'h34);
    do_req(2'd0, 6'h07, 6'h00, 8'h00);
    wait_idle();
    chk("stats_ld3", ld_count, 3);
    chk("stats_st2", st_count, 2);
    preset_ld = 1'b1;
    force dut.ld_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.ld_cnt_q;
    preset_ld = 1'b0;
    do_req(2'd0, 6'h08, 6'h00, 8'h00);
    wait_idle();
    chk("stats_ld_sat", ld_count, 16'hFFFF);
    rr_val = 1'b0;
`endif

    // randomized traffic with occasional resets
    rr_force = 1'b0;
    for (int i = 0; i < 400; i++) begin
      do_req(2'($urandom_range(0, 3)), AW'($urandom), AW'($urandom), DW'($urandom));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rr_force = 1'b1;
    rr_val = 1'b1;
    wait_idle();
    nmis = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) nmis++;
    chk("mem_image", nmis, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
